bsg_sdo_channel_sched: RTL



---
 rtl/bsg_sdo_channel_sched_if.sv | 27 ++
 rtl/bsg_sdo_channel_sched.sv | 116 +++++++++++
 2 files changed

// File: rtl/bsg_sdo_channel_sched_if.sv
// Bundle of requester-side and channel-side signals of the SDO channel scheduler.
// The scheduler uses the slave modport; the core/serializer side uses the master modport.
interface bsg_sdo_channel_sched_if #(
  parameter int num_req_p  = 4,
  parameter int channels_p = 4,
  parameter int width_p    = 9
);
  logic [num_req_p-1:0]          req_v_i;
  logic [num_req_p*width_p-1:0]  req_data_i;
  logic [num_req_p-1:0]          req_last_i;
  logic [num_req_p-1:0]          req_yumi_o;
  logic [channels_p-1:0]         chan_v_o;
  logic [channels_p*width_p-1:0] chan_data_o;
  logic [channels_p-1:0]         token_i;
  logic [channels_p-1:0]         credit_avail_o;
  logic                          overflow_o;

  modport master (
    output req_v_i, req_data_i, req_last_i, token_i,
    input  req_yumi_o, chan_v_o, chan_data_o, credit_avail_o, overflow_o
  );

  modport slave (
    input  req_v_i, req_data_i, req_last_i, token_i,
    output req_yumi_o, chan_v_o, chan_data_o, credit_avail_o, overflow_o
  );
endinterface

// File: rtl/bsg_sdo_channel_sched.sv
// Round-robin packet arbiter that stripes flits across output channels in a fixed
// rotating order, gated by per-channel token credits returned from the far side.
module bsg_sdo_channel_sched #(
  parameter int num_req_p  = 4,
  parameter int channels_p = 4,
  parameter int width_p    = 9,
  parameter int credits_p  = 16
) (
  input logic clk_i,
  input logic reset_i,
  bsg_sdo_channel_sched_if.slave bus
);
  localparam int cnt_w = $clog2(credits_p + 1);
  localparam int sp_w  = (channels_p > 1) ? $clog2(channels_p) : 1;
  localparam int rr_w  = $clog2(num_req_p);
  localparam logic [cnt_w-1:0] credit_full = cnt_w'(credits_p);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                state, state_n;
  logic [rr_w-1:0]       rr_ptr, rr_n;
  logic [rr_w-1:0]       grant, grant_n;
  logic [sp_w-1:0]       stripe_ptr, stripe_n;
  logic [cnt_w-1:0]      credit [channels_p];
  logic [rr_w-1:0]       cand;
  logic                  cand_v;
  logic                  found;
  logic                  accept;
  logic [width_p-1:0]    cand_data;
  logic [rr_w-1:0]       cand_inc;
  logic [channels_p-1:0] chan_dec;
  logic                  overflow_set;
  int                    idx;

  // Candidate selection, acceptance and next-state decode. The stripe channel's
  // credit alone gates acceptance: skipping a starved channel would reorder flits.
  always_comb begin
    cand         = grant;
    cand_v       = 1'b0;
    found        = 1'b0;
    idx          = 0;
    state_n      = state;
    grant_n      = grant;
    rr_n         = rr_ptr;
    stripe_n     = stripe_ptr;
    bus.req_yumi_o = '0;
    chan_dec     = '0;
    overflow_set = 1'b0;

    if (state == LOCKED) begin
      cand   = grant;
      cand_v = bus.req_v_i[grant];
    end else begin
      for (int i = 0; i < num_req_p; i++) begin
        idx = (int'(rr_ptr) + i) % num_req_p;
        if (!found && bus.req_v_i[idx]) begin
          found  = 1'b1;
          cand   = rr_w'(idx);
          cand_v = 1'b1;
        end
      end
    end

    accept    = cand_v && (credit[stripe_ptr] != '0) && !reset_i;
    cand_data = bus.req_data_i[int'(cand)*width_p +: width_p];
    cand_inc  = (cand == rr_w'(num_req_p - 1)) ? '0 : cand + rr_w'(1);

    if (accept) begin
      bus.req_yumi_o[cand] = 1'b1;
      chan_dec[stripe_ptr] = 1'b1;
      stripe_n = (stripe_ptr == sp_w'(channels_p - 1)) ? '0 : stripe_ptr + sp_w'(1);
      if (bus.req_last_i[cand]) begin
        state_n = IDLE;
        rr_n    = cand_inc;
      end else begin
        state_n = LOCKED;
        grant_n = cand;
      end
    end

    for (int c = 0; c < channels_p; c++) begin
      if (bus.token_i[c] && !chan_dec[c] && credit[c] == credit_full) overflow_set = 1'b1;
    end
  end

  always_comb begin
    for (int c = 0; c < channels_p; c++) bus.credit_avail_o[c] = (credit[c] != '0);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      stripe_ptr  <= '0;
      bus.chan_v_o    <= '0;
      bus.chan_data_o <= '0;
      bus.overflow_o  <= 1'b0;
      for (int c = 0; c < channels_p; c++) credit[c] <= credit_full;
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_n;
      grant      <= grant_n;
      stripe_ptr <= stripe_n;
      bus.chan_v_o <= chan_dec;
      if (overflow_set) bus.overflow_o <= 1'b1;
      // A same-cycle token and decrement cancel; a token on a full counter is dropped.
      for (int c = 0; c < channels_p; c++) begin
        if (chan_dec[c]) bus.chan_data_o[c*width_p +: width_p] <= cand_data;
        if (chan_dec[c] && !bus.token_i[c]) credit[c] <= credit[c] - cnt_w'(1);
        else if (bus.token_i[c] && !chan_dec[c] && credit[c] != credit_full)
          credit[c] <= credit[c] + cnt_w'(1);
      end
    end
  end
endmodule
